axi_write_router: RTL and testbench
===================================

// Module: axi_write_router
// PURPOSE
// - Routes one master-side AXI write transaction (AW, W, B) to one of two mapped slaves or to the default slave.
// - Sits directly upstream of the default slave in the interconnect.
// - Sits downstream of the write arbiter.
// - Only one write is outstanding at a time. The target is locked from AW handshake to B handshake.
// PARAMETERS
// - IDW     8             ID width
// - ADW     32            address width
// - S0_BASE 32'h0000_0000 slave 0 base; S0_MASK 32'hFFFF_0000 compare mask
// - S1_BASE 32'h0001_0000 slave 1 base; S1_MASK 32'hFFFF_0000 compare mask
// PORTS
// - ACLK      in  1     clock
// - ARESETn   in  1     asynchronous, active-low reset
// - AWID_M    in  IDW   master write ID
// - AWADDR_M  in  ADW   master write address
// - AWLEN_M   in  4     burst length minus 1
// - AWVALID_M in  1     master AW valid
// - AWREADY_M out 1     master AW ready
// - WDATA_M   in  32    master write data
// - WSTRB_M   in  4     master write strobes
// - WLAST_M   in  1     master last beat
// - WVALID_M  in  1     master W valid
// - WREADY_M  out 1     master W ready
// - BID_M     out IDW   response ID to master
// - BRESP_M   out 2     response code to master
// - BVALID_M  out 1     master B valid
// - BREADY_M  in  1     master B ready
// - AWID_S/AWADDR_S/AWLEN_S out IDW/ADW/4   latched AW fields, broadcast to all slaves
// - WDATA_S/WSTRB_S/WLAST_S out 32/4/1      W fields broadcast to all slaves; WLAST_S is router-generated
// - AWVALID_S out 3   one-hot AW valid: [0]=S0, [1]=S1, [2]=default slave
// - AWREADY_S in  3   per-target AW ready
// - WVALID_S  out 3   one-hot W valid
// - WREADY_S  in  3   per-target W ready
// - BID_S     in  3*IDW per-target response ID
// - BRESP_S   in  2*2 response code from S0/S1 only; the default slave has no BRESP
// - BVALID_S  in  3   per-target B valid
// - BREADY_S  out 3   one-hot B ready
// - err_wlast out 1   one-cycle pulse on a WLAST/beat-count mismatch
// BEHAVIOUR
// - Reset: FSM=IDLE, all latched fields and beat counter 0, every valid/ready output 0, err_wlast 0.
// - Reset mid-transaction abandons it. No response is issued.
// - Decode, priority S0 > S1 > DEFAULT: hit if (AWADDR_M & MASK) == BASE. Anything else goes to DEFAULT.
// - IDLE: AWVALID_S[sel] = AWVALID_M; AWREADY_M = AWREADY_S[sel]. Combinational pass-through, zero added latency.
// - IDLE: on AW handshake, latch ID/ADDR/LEN/sel, clear beat counter, go to DATA.
// - DATA: WVALID_S[sel] = WVALID_M; WREADY_M = WREADY_S[sel]; AWREADY_M = 0.
// - DATA: WLAST_S = (beat == len_q). Each W handshake increments beat.
// - DATA: the handshake where beat == len_q goes to RESP.
// - DATA, DEFAULT target: beats before the last are absorbed locally (WREADY_M = 1, WVALID_S = 0). Only the final beat is forwarded, because the default slave leaves its data state on any single beat.
// - DATA: if WLAST_M != (beat == len_q) on a handshake, pulse err_wlast. Routing still follows the counter.
// - RESP: BVALID_M = BVALID_S[sel]; BREADY_S[sel] = BREADY_M; BID_M = BID_S[sel].
// - RESP: BRESP_M = BRESP_S[sel] for S0/S1; forced to 2'b11 (DECERR) for DEFAULT.
// - RESP: on B handshake, return to IDLE. A new AW is not accepted in that same cycle.
// - Outside RESP: BVALID_M = 0, BID_M = 0, BRESP_M = 0.
// - Non-selected one-hot bits are always 0.
// - Beat counter is 4 bits. LEN=15 reaches beat=15 with no wrap; the counter clears on entry to DATA.
// STRUCTURE
// - axi_pkg: IDW/ADW localparams, BRESP codes (OKAY=2'b00, DECERR=2'b11).
// - axi_pkg: typedef enum {TGT_S0, TGT_S1, TGT_DEF} tgt_e; typedef enum {IDLE, DATA, RESP} wr_state_e.
// - Sub-module axi_addr_decode: combinational address -> tgt_e. Shared with the future read router.
// TESTING
// - Reset asserted, then released -> all valids/readies 0.
// - First AW at AWADDR=0x0001_0004 -> AWVALID_S = 3'b010.
// - AW 0x0000_0010, ID=8'h21, LEN=0, one beat, S0 returns BRESP=0 -> BID_M=8'h21, BRESP_M=2'b00, back to IDLE.
// - AW 0x8000_0000, ID=8'h5A, LEN=3 -> 3 beats absorbed with WVALID_S=0.
// - Same case, 4th beat -> WVALID_S=3'b100 with WLAST_S=1; then BID_M=8'h5A, BRESP_M=2'b11.
// - LEN=1 with WLAST_M on beat 0 -> err_wlast pulses once; transfer still completes after 2 beats.
// - BREADY_M held low 5 cycles in RESP -> BVALID_M stays 1, no new AW accepted.
// - ARESETn dropped in DATA -> outputs 0 immediately; next AW after release is routed normally.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_pkg
//  Purpose  : Shared AXI write-path types and constants: default ID/address
//             widths, BRESP codes, routing-target and write-FSM enums, and a
//             target-to-one-hot helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam int IDW = 8;
    localparam int ADW = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        TGT_S0  = 2'd0,
        TGT_S1  = 2'd1,
        TGT_DEF = 2'd2
    } tgt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    // Bit position matches the slave-side one-hot buses: [0]=S0, [1]=S1, [2]=default.
    function automatic logic [2:0] tgt_onehot(input tgt_e t);
        case (t)
            TGT_S0:  return 3'b001;
            TGT_S1:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : axi_addr_decode
//  Purpose  : Combinational address decoder. S0 has priority over S1; any
//             address that hits neither window maps to the default slave.
//             Kept standalone so the read router can reuse it.
//  Ports    : i_addr  in  ADW   address to decode
//             o_tgt   out tgt_e selected target
//  Revision : 1.0 - initial release
// ============================================================================
module axi_addr_decode #(
    parameter int             ADW     = 32,
    parameter logic [ADW-1:0] S0_BASE = 32'h0000_0000,
    parameter logic [ADW-1:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [ADW-1:0] S1_BASE = 32'h0001_0000,
    parameter logic [ADW-1:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic [ADW-1:0] i_addr,
    output axi_pkg::tgt_e  o_tgt
);
    import axi_pkg::*;

    always_comb begin
        o_tgt = TGT_DEF;
        if ((i_addr & S0_MASK) == S0_BASE) begin
            o_tgt = TGT_S0;
        end else if ((i_addr & S1_MASK) == S1_BASE) begin
            o_tgt = TGT_S1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_write_router.sv
`default_nettype none
// ============================================================================
//  Module   : axi_write_router
//  Purpose  : Routes a single outstanding AXI write (AW, W, B) from the
//             arbiter to slave 0, slave 1 or the default slave. The target is
//             locked from the AW handshake until the B handshake.
//  Ports    : ACLK/ARESETn              clock, async active-low reset
//             AW*_M / W*_M / B*_M       master-side write channels
//             AW*_S / W*_S              fields broadcast to all slaves
//             *VALID_S/*READY_S         one-hot per target [0]=S0 [1]=S1 [2]=DEF
//             BID_S/BRESP_S/BVALID_S    per-target responses (no BRESP on DEF)
//             err_wlast                 pulse on WLAST vs beat-count mismatch
//  Revision : 1.0 - initial release
// ============================================================================
module axi_write_router #(
    parameter int             IDW     = axi_pkg::IDW,
    parameter int             ADW     = axi_pkg::ADW,
    parameter logic [ADW-1:0] S0_BASE = 32'h0000_0000,
    parameter logic [ADW-1:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [ADW-1:0] S1_BASE = 32'h0001_0000,
    parameter logic [ADW-1:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    // master side
    input  logic [IDW-1:0]   AWID_M,
    input  logic [ADW-1:0]   AWADDR_M,
    input  logic [3:0]       AWLEN_M,
    input  logic             AWVALID_M,
    output logic             AWREADY_M,
    input  logic [31:0]      WDATA_M,
    input  logic [3:0]       WSTRB_M,
    input  logic             WLAST_M,
    input  logic             WVALID_M,
    output logic             WREADY_M,
    output logic [IDW-1:0]   BID_M,
    output logic [1:0]       BRESP_M,
    output logic             BVALID_M,
    input  logic             BREADY_M,
    // slave side
    output logic [IDW-1:0]   AWID_S,
    output logic [ADW-1:0]   AWADDR_S,
    output logic [3:0]       AWLEN_S,
    output logic [31:0]      WDATA_S,
    output logic [3:0]       WSTRB_S,
    output logic             WLAST_S,
    output logic [2:0]       AWVALID_S,
    input  logic [2:0]       AWREADY_S,
    output logic [2:0]       WVALID_S,
    input  logic [2:0]       WREADY_S,
    input  logic [3*IDW-1:0] BID_S,
    input  logic [3:0]       BRESP_S,
    input  logic [2:0]       BVALID_S,
    output logic [2:0]       BREADY_S,
    output logic             err_wlast
);
    import axi_pkg::*;

    wr_state_e      state_q, state_d;
    tgt_e           sel_q, sel_d;
    logic [IDW-1:0] id_q, id_d;
    logic [ADW-1:0] addr_q, addr_d;
    logic [3:0]     len_q, len_d;
    logic [3:0]     beat_q, beat_d;

    tgt_e           w_dec_tgt;
    logic [2:0]     w_dec_oh;
    logic [2:0]     w_sel_oh;
    logic           w_last_beat;

    axi_addr_decode #(
        .ADW     (ADW),
        .S0_BASE (S0_BASE),
        .S0_MASK (S0_MASK),
        .S1_BASE (S1_BASE),
        .S1_MASK (S1_MASK)
    ) u_dec (
        .i_addr (AWADDR_M),
        .o_tgt  (w_dec_tgt)
    );

    assign w_dec_oh    = tgt_onehot(w_dec_tgt);
    assign w_sel_oh    = tgt_onehot(sel_q);
    assign w_last_beat = (beat_q == len_q);

    // Latched AW fields go to every slave; only the one-hot valid selects.
    assign AWID_S   = id_q;
    assign AWADDR_S = addr_q;
    assign AWLEN_S  = len_q;
    assign WDATA_S  = WDATA_M;
    assign WSTRB_S  = WSTRB_M;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            sel_q   <= TGT_S0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        AWVALID_S = 3'b000;
        AWREADY_M = 1'b0;
        WVALID_S  = 3'b000;
        WREADY_M  = 1'b0;
        WLAST_S   = 1'b0;
        BVALID_M  = 1'b0;
        BREADY_S  = 3'b000;
        BID_M     = '0;
        BRESP_M   = RESP_OKAY;
        err_wlast = 1'b0;

        case (state_q)
            IDLE: begin
                // Zero-latency pass-through of the decoded AW handshake.
                AWVALID_S = w_dec_oh & {3{AWVALID_M}};
                AWREADY_M = |(w_dec_oh & AWREADY_S);
                if (AWVALID_M && AWREADY_M) begin
                    sel_d   = w_dec_tgt;
                    id_d    = AWID_M;
                    addr_d  = AWADDR_M;
                    len_d   = AWLEN_M;
                    beat_d  = '0;
                    state_d = DATA;
                end
            end

            DATA: begin
                WLAST_S = w_last_beat;
                // The default slave leaves its data state after any beat, so
                // only the final beat reaches it; earlier beats are sunk here.
                if (sel_q == TGT_DEF && !w_last_beat) begin
                    WREADY_M = 1'b1;
                end else begin
                    WVALID_S = w_sel_oh & {3{WVALID_M}};
                    WREADY_M = |(w_sel_oh & WREADY_S);
                end
                if (WVALID_M && WREADY_M) begin
                    // Routing trusts the counter; a disagreeing WLAST only flags.
                    err_wlast = (WLAST_M != w_last_beat);
                    if (w_last_beat) begin
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end

            RESP: begin
                BVALID_M = |(w_sel_oh & BVALID_S);
                BREADY_S = w_sel_oh & {3{BREADY_M}};
                case (sel_q)
                    TGT_S0: begin
                        BID_M   = BID_S[IDW-1:0];
                        BRESP_M = BRESP_S[1:0];
                    end
                    TGT_S1: begin
                        BID_M   = BID_S[2*IDW-1:IDW];
                        BRESP_M = BRESP_S[3:2];
                    end
                    default: begin
                        BID_M   = BID_S[3*IDW-1:2*IDW];
                        BRESP_M = RESP_DECERR;
                    end
                endcase
                if (BVALID_M && BREADY_M) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axi_write_router
//  Purpose  : Self-checking bench for axi_write_router. Expected B responses
//             are queued when AW is issued and compared when B is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_write_router;
    localparam int IDW = 8;
    localparam int ADW = 32;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic [IDW-1:0]   AWID_M;
    logic [ADW-1:0]   AWADDR_M;
    logic [3:0]       AWLEN_M;
    logic             AWVALID_M;
    logic             AWREADY_M;
    logic [31:0]      WDATA_M;
    logic [3:0]       WSTRB_M;
    logic             WLAST_M;
    logic             WVALID_M;
    logic             WREADY_M;
    logic [IDW-1:0]   BID_M;
    logic [1:0]       BRESP_M;
    logic             BVALID_M;
    logic             BREADY_M;
    logic [IDW-1:0]   AWID_S;
    logic [ADW-1:0]   AWADDR_S;
    logic [3:0]       AWLEN_S;
    logic [31:0]      WDATA_S;
    logic [3:0]       WSTRB_S;
    logic             WLAST_S;
    logic [2:0]       AWVALID_S;
    logic [2:0]       AWREADY_S;
    logic [2:0]       WVALID_S;
    logic [2:0]       WREADY_S;
    logic [3*IDW-1:0] BID_S;
    logic [3:0]       BRESP_S;
    logic [2:0]       BVALID_S;
    logic [2:0]       BREADY_S;
    logic             err_wlast;

    always #5 ACLK = ~ACLK;

    axi_write_router dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
        .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
        .WVALID_M(WVALID_M), .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .err_wlast(err_wlast)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        logic [2:0]     oh;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference decode: S0 = 0x0000_xxxx, S1 = 0x0001_xxxx, everything else default.
    function automatic logic [2:0] model_oh(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 3'b001;
        if (a[31:16] == 16'h0001) return 3'b010;
        return 3'b100;
    endfunction

    // Slave models: S0 answers OKAY, S1 answers EXOKAY, default must become DECERR.
    function automatic logic [1:0] model_resp(input logic [2:0] oh);
        case (oh)
            3'b001:  return 2'b00;
            3'b010:  return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_aw(input logic [31:0] addr, input logic [7:0] id, input logic [3:0] len,
                            output logic [2:0] vs, output logic rdy);
        exp_t e;
        AWADDR_M = addr; AWID_M = id; AWLEN_M = len; AWVALID_M = 1'b1;
        #1;
        vs  = AWVALID_S;
        rdy = AWREADY_M;
        tick();
        AWVALID_M = 1'b0;
        e.id = id; e.oh = model_oh(addr); e.resp = model_resp(e.oh);
        sb.push_back(e);
    endtask

    task automatic drive_w(input logic last, output logic [2:0] vs, output logic wl,
                           output logic rdy, output logic err);
        WDATA_M = $urandom; WSTRB_M = 4'hF; WLAST_M = last; WVALID_M = 1'b1;
        #1;
        vs = WVALID_S; wl = WLAST_S; rdy = WREADY_M; err = err_wlast;
        tick();
        WVALID_M = 1'b0; WLAST_M = 1'b0;
    endtask

    // Target slave echoes the latched ID; other slots carry a decoy.
    task automatic slave_b_setup(input logic [2:0] oh);
        for (int k = 0; k < 3; k++)
            BID_S[k*IDW +: IDW] = oh[k] ? AWID_S : ~AWID_S;
        BVALID_S = oh;
    endtask

    task automatic drive_b(input logic [2:0] oh, output logic bv,
                           output logic [IDW-1:0] bid, output logic [1:0] br);
        slave_b_setup(oh);
        BREADY_M = 1'b1;
        #1;
        bv = BVALID_M; bid = BID_M; br = BRESP_M;
        tick();
        BVALID_S = 3'b000; BREADY_M = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        ARESETn = 1'b0;
        AWID_M = '0; AWADDR_M = '0; AWLEN_M = '0; AWVALID_M = 1'b0;
        WDATA_M = '0; WSTRB_M = '0; WLAST_M = 1'b0; WVALID_M = 1'b0; BREADY_M = 1'b0;
        AWREADY_S = 3'b000; WREADY_S = 3'b000; BID_S = '0; BRESP_S = 4'b0100; BVALID_S = 3'b000;
        repeat (3) tick();
        ARESETn = 1'b1;
        tick();
        n_cmp++;
        if ({AWREADY_M, WREADY_M, BVALID_M, err_wlast} !== 4'b0000) begin
            n_err++; $display("FAIL reset_m_ctrl: got %b exp 0000", {AWREADY_M, WREADY_M, BVALID_M, err_wlast});
        end
        n_cmp++;
        if ({AWVALID_S, WVALID_S, BREADY_S} !== 9'd0) begin
            n_err++; $display("FAIL reset_s_ctrl: got %b exp 0", {AWVALID_S, WVALID_S, BREADY_S});
        end
        n_cmp++;
        if ({AWID_S, AWADDR_S, AWLEN_S, WLAST_S, BID_M, BRESP_M} !== '0) begin
            n_err++; $display("FAIL reset_fields: got %h exp 0", {AWID_S, AWADDR_S, AWLEN_S, WLAST_S, BID_M, BRESP_M});
        end
    endtask

    task automatic test_route_s1();
        logic [2:0] vs; logic rdy, wl, err, bv; logic [IDW-1:0] bid; logic [1:0] br; exp_t e;
        AWADDR_M = 32'h0001_0004; AWID_M = 8'h11; AWLEN_M = 4'd0; AWVALID_M = 1'b1;
        #1;
        n_cmp++;
        if (AWVALID_S !== 3'b010) begin n_err++; $display("FAIL s1_awvalid: got %b exp 010", AWVALID_S); end
        n_cmp++;
        if (AWREADY_M !== 1'b0) begin n_err++; $display("FAIL s1_awready_stall: got %b exp 0", AWREADY_M); end
        tick();
        AWREADY_S = 3'b111; WREADY_S = 3'b111;
        drive_aw(32'h0001_0004, 8'h11, 4'd0, vs, rdy);
        drive_w(1'b1, vs, wl, rdy, err);
        n_cmp++;
        if (vs !== 3'b010) begin n_err++; $display("FAIL s1_wvalid: got %b exp 010", vs); end
        drive_b(3'b010, bv, bid, br);
        e = sb.pop_front();
        n_cmp++;
        if ({bv, bid, br} !== {1'b1, e.id, e.resp}) begin
            n_err++; $display("FAIL s1_b: got v%b id%h r%b exp v1 id%h r%b", bv, bid, br, e.id, e.resp);
        end
    endtask

    task automatic test_s0_single();
        logic [2:0] vs; logic rdy, wl, err, bv; logic [IDW-1:0] bid; logic [1:0] br; exp_t e;
        drive_aw(32'h0000_0010, 8'h21, 4'd0, vs, rdy);
        n_cmp++;
        if ({vs, rdy} !== 4'b0011) begin n_err++; $display("FAIL s0_aw: got vs%b rdy%b exp 001/1", vs, rdy); end
        drive_w(1'b1, vs, wl, rdy, err);
        n_cmp++;
        if ({vs, wl, rdy, err} !== 6'b001110) begin
            n_err++; $display("FAIL s0_w: got vs%b last%b rdy%b err%b exp 001/1/1/0", vs, wl, rdy, err);
        end
        drive_b(3'b001, bv, bid, br);
        e = sb.pop_front();
        n_cmp++;
        if ({bv, bid, br} !== {1'b1, 8'h21, 2'b00} || {bid, br} !== {e.id, e.resp}) begin
            n_err++; $display("FAIL s0_b: got v%b id%h r%b exp v1 id21 r00", bv, bid, br);
        end
        n_cmp++;
        if ({AWREADY_M, WREADY_M, BVALID_M} !== 3'b100) begin
            n_err++; $display("FAIL s0_idle: got %b exp 100", {AWREADY_M, WREADY_M, BVALID_M});
        end
    endtask

    task automatic test_default_burst();
        logic [2:0] vs; logic rdy, wl, err, bv; logic [IDW-1:0] bid; logic [1:0] br; exp_t e;
        drive_aw(32'h8000_0000, 8'h5A, 4'd3, vs, rdy);
        n_cmp++;
        if (vs !== 3'b100) begin n_err++; $display("FAIL def_awvalid: got %b exp 100", vs); end
        for (int b = 0; b < 3; b++) begin
            drive_w(1'b0, vs, wl, rdy, err);
            n_cmp++;
            if ({vs, wl, rdy, err} !== 6'b000010) begin
                n_err++; $display("FAIL def_absorb%0d: got vs%b last%b rdy%b err%b exp 000/0/1/0", b, vs, wl, rdy, err);
            end
        end
        drive_w(1'b1, vs, wl, rdy, err);
        n_cmp++;
        if ({vs, wl, rdy, err} !== 6'b100110) begin
            n_err++; $display("FAIL def_last: got vs%b last%b rdy%b err%b exp 100/1/1/0", vs, wl, rdy, err);
        end
        drive_b(3'b100, bv, bid, br);
        e = sb.pop_front();
        n_cmp++;
        if ({bv, bid, br} !== {1'b1, e.id, e.resp}) begin
            n_err++; $display("FAIL def_b: got v%b id%h r%b exp v1 id%h r%b", bv, bid, br, e.id, e.resp);
        end
    endtask

    task automatic test_wlast_err();
        logic [2:0] vs; logic rdy, wl, err, bv; logic [IDW-1:0] bid; logic [1:0] br; exp_t e;
        int pulses = 0;
        drive_aw(32'h0000_0100, 8'h33, 4'd1, vs, rdy);
        drive_w(1'b1, vs, wl, rdy, err);
        pulses += int'(err);
        n_cmp++;
        if ({wl, err} !== 2'b01) begin n_err++; $display("FAIL wlast_early: got last%b err%b exp 0/1", wl, err); end
        drive_w(1'b1, vs, wl, rdy, err);
        pulses += int'(err);
        n_cmp++;
        if ({wl, err, vs} !== 5'b10001) begin n_err++; $display("FAIL wlast_final: got last%b err%b vs%b exp 1/0/001", wl, err, vs); end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL wlast_pulses: got %0d exp 1", pulses); end
        drive_b(3'b001, bv, bid, br);
        e = sb.pop_front();
        n_cmp++;
        if ({bv, bid, br} !== {1'b1, e.id, e.resp}) begin
            n_err++; $display("FAIL wlast_b: got v%b id%h r%b exp v1 id%h r%b", bv, bid, br, e.id, e.resp);
        end
    endtask

    task automatic test_bready_hold();
        logic [2:0] vs; logic rdy, wl, err; exp_t e;
        drive_aw(32'h0001_0040, 8'h77, 4'd0, vs, rdy);
        drive_w(1'b1, vs, wl, rdy, err);
        slave_b_setup(3'b010);
        BREADY_M = 1'b0;
        AWADDR_M = 32'h0000_0010; AWVALID_M = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({BVALID_M, AWREADY_M, BREADY_S} !== 5'b10000) begin
                n_err++; $display("FAIL hold_c%0d: got bv%b awr%b brs%b exp 1/0/000", c, BVALID_M, AWREADY_M, BREADY_S);
            end
            tick();
        end
        BREADY_M = 1'b1;
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({BVALID_M, AWREADY_M, BREADY_S, BID_M, BRESP_M} !== {2'b10, 3'b010, e.id, e.resp}) begin
            n_err++; $display("FAIL hold_release: got bv%b awr%b brs%b id%h r%b exp 1/0/010 id%h r%b",
                              BVALID_M, AWREADY_M, BREADY_S, BID_M, BRESP_M, e.id, e.resp);
        end
        tick();
        AWVALID_M = 1'b0; BVALID_S = 3'b000; BREADY_M = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [2:0] vs; logic rdy, wl, err, bv; logic [IDW-1:0] bid; logic [1:0] br; exp_t e;
        drive_aw(32'h0000_2000, 8'h44, 4'd3, vs, rdy);
        drive_w(1'b0, vs, wl, rdy, err);
        WVALID_M = 1'b1;
        ARESETn = 1'b0;
        #1;
        n_cmp++;
        if ({WREADY_M, WVALID_S, WLAST_S, BVALID_M} !== 6'd0 || {AWID_S, AWLEN_S} !== '0) begin
            n_err++; $display("FAIL rstmid_out: got wr%b ws%b wl%b bv%b id%h len%h exp all 0",
                              WREADY_M, WVALID_S, WLAST_S, BVALID_M, AWID_S, AWLEN_S);
        end
        WVALID_M = 1'b0;
        sb.delete();
        tick(); tick();
        ARESETn = 1'b1;
        tick();
        drive_aw(32'h0001_0008, 8'h99, 4'd0, vs, rdy);
        n_cmp++;
        if ({vs, rdy} !== 4'b0101) begin n_err++; $display("FAIL rstmid_aw: got vs%b rdy%b exp 010/1", vs, rdy); end
        drive_w(1'b1, vs, wl, rdy, err);
        drive_b(3'b010, bv, bid, br);
        e = sb.pop_front();
        n_cmp++;
        if ({bv, bid, br} !== {1'b1, e.id, e.resp}) begin
            n_err++; $display("FAIL rstmid_b: got v%b id%h r%b exp v1 id%h r%b", bv, bid, br, e.id, e.resp);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] vs; logic rdy, wl, err, bv; logic [IDW-1:0] bid; logic [1:0] br; exp_t e;
        logic [31:0] addr; logic [3:0] len;
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 2))
                0:       addr = {16'h0000, 16'($urandom)};
                1:       addr = {16'h0001, 16'($urandom)};
                default: addr = {16'($urandom_range(2, 16'hFFFF)), 16'($urandom)};
            endcase
            len = (t == 7) ? 4'd15 : 4'($urandom_range(0, 3));
            drive_aw(addr, 8'($urandom), len, vs, rdy);
            e = sb[$];
            n_cmp++;
            if (vs !== e.oh) begin n_err++; $display("FAIL b2b_aw%0d: got %b exp %b", t, vs, e.oh); end
            for (int b = 0; b <= int'(len); b++) begin
                drive_w(b == int'(len), vs, wl, rdy, err);
                if (b == int'(len)) begin
                    n_cmp++;
                    if ({vs, wl, err} !== {e.oh, 2'b10}) begin
                        n_err++; $display("FAIL b2b_w%0d: got vs%b last%b err%b exp %b/1/0", t, vs, wl, err, e.oh);
                    end
                end
            end
            drive_b(e.oh, bv, bid, br);
            e = sb.pop_front();
            n_cmp++;
            if ({bv, bid, br} !== {1'b1, e.id, e.resp}) begin
                n_err++; $display("FAIL b2b_b%0d: got v%b id%h r%b exp v1 id%h r%b", t, bv, bid, br, e.id, e.resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_route_s1();
        test_s0_single();
        test_default_burst();
        test_wlast_err();
        test_bready_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
